// File: rtl/mips_core_pkg.sv
// rtl/mips_core_pkg.sv - shared core types for branch tracking
package mips_core_pkg;

    localparam int ADDR_WIDTH = 32;

    typedef enum logic {
        NOT_TAKEN = 1'b0,
        TAKEN     = 1'b1
    } BranchOutcome;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [ADDR_WIDTH-1:0] target;
        BranchOutcome          prediction;
        BranchOutcome          outcome;
    } brq_entry_t;

    // A taken branch to the wrong place is as much a mispredict as a wrong direction.
    function automatic logic is_mispredict(
        input BranchOutcome          prediction,
        input BranchOutcome          outcome,
        input logic [ADDR_WIDTH-1:0] predicted_target,
        input logic [ADDR_WIDTH-1:0] actual_target
    );
        return (outcome != prediction) ||
               ((outcome == TAKEN) && (actual_target != predicted_target));
    endfunction

endpackage

// File: rtl/branch_resolution_queue_if.sv
// rtl/branch_resolution_queue_if.sv - predict/resolve/feedback bundle of the branch queue
interface branch_resolution_queue_if #(
    parameter int DEPTH = 8
);
    import mips_core_pkg::*;

    localparam int TAG_W = $clog2(DEPTH);

    logic                  i_pred_valid;
    logic [ADDR_WIDTH-1:0] i_pred_pc;
    logic [ADDR_WIDTH-1:0] i_pred_target;
    BranchOutcome          i_pred_prediction;
    logic                  o_pred_ready;
    logic [TAG_W-1:0]      o_pred_tag;

    logic                  i_res_valid;
    logic [TAG_W-1:0]      i_res_tag;
    BranchOutcome          i_res_outcome;
    logic [ADDR_WIDTH-1:0] i_res_target;

    logic                  o_mispredict;
    logic [ADDR_WIDTH-1:0] o_redirect_pc;

    logic                  o_fb_valid;
    logic [ADDR_WIDTH-1:0] o_fb_pc;
    BranchOutcome          o_fb_prediction;
    BranchOutcome          o_fb_outcome;

    logic [31:0]           o_branch_count;
    logic [31:0]           o_mispredict_count;

    modport slave (
        input  i_pred_valid, i_pred_pc, i_pred_target, i_pred_prediction,
        output o_pred_ready, o_pred_tag,
        input  i_res_valid, i_res_tag, i_res_outcome, i_res_target,
        output o_mispredict, o_redirect_pc,
        output o_fb_valid, o_fb_pc, o_fb_prediction, o_fb_outcome,
        output o_branch_count, o_mispredict_count
    );

    modport master (
        output i_pred_valid, i_pred_pc, i_pred_target, i_pred_prediction,
        input  o_pred_ready, o_pred_tag,
        output i_res_valid, i_res_tag, i_res_outcome, i_res_target,
        input  o_mispredict, o_redirect_pc,
        input  o_fb_valid, o_fb_pc, o_fb_prediction, o_fb_outcome,
        input  o_branch_count, o_mispredict_count
    );

endinterface

// File: rtl/branch_stats_counter.sv
// rtl/branch_stats_counter.sv - wrapping retired-branch and mispredict counters
module branch_stats_counter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc_branch,
    input  logic        inc_mispredict,
    output logic [31:0] branch_count,
    output logic [31:0] mispredict_count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            if (inc_branch)
                branch_count <= branch_count + 32'd1;
            if (inc_mispredict)
                mispredict_count <= mispredict_count + 32'd1;
        end
    end

endmodule

// File: rtl/branch_resolution_queue.sv
// rtl/branch_resolution_queue.sv - in-flight branch tracker: mispredict redirect, squash, in-order feedback
module branch_resolution_queue #(
    parameter int DEPTH              = 8,
    parameter int FALLTHROUGH_OFFSET = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    branch_resolution_queue_if.slave  bus
);
    import mips_core_pkg::*;

    localparam int TAG_W = $clog2(DEPTH);

    typedef logic [TAG_W:0]   ptr_t;
    typedef logic [TAG_W-1:0] idx_t;

    ptr_t             head;
    ptr_t             tail;
    ptr_t             count;
    idx_t             head_idx;
    idx_t             tail_idx;
    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] resolved;
    brq_entry_t       entries [DEPTH];

    logic             res_hit;
    logic             res_misp;
    logic             alloc;
    logic             retire;
    idx_t             res_offset;
    ptr_t             squash_tail;
    logic [ADDR_WIDTH-1:0] redirect_next;

    logic [DEPTH-1:0] alloc_mask;
    logic [DEPTH-1:0] resolve_mask;
    logic [DEPTH-1:0] retire_mask;
    logic [DEPTH-1:0] squash_mask;

    logic                  fb_valid;
    logic [ADDR_WIDTH-1:0] fb_pc;
    BranchOutcome          fb_prediction;
    BranchOutcome          fb_outcome;
    logic                  mispredict;
    logic [ADDR_WIDTH-1:0] redirect_pc;

    assign count    = tail - head;
    assign head_idx = head[TAG_W-1:0];
    assign tail_idx = tail[TAG_W-1:0];

    assign bus.o_pred_ready = (count != ptr_t'(DEPTH));
    assign bus.o_pred_tag   = tail_idx;

    // Stale, squashed and duplicate tags fail this test and leave no trace.
    assign res_hit  = bus.i_res_valid && valid[bus.i_res_tag] && !resolved[bus.i_res_tag];
    assign res_misp = res_hit && is_mispredict(entries[bus.i_res_tag].prediction,
                                               bus.i_res_outcome,
                                               entries[bus.i_res_tag].target,
                                               bus.i_res_target);

    // A wrong-path allocation racing a mispredict must not survive the squash.
    assign alloc  = bus.i_pred_valid && bus.o_pred_ready && !res_misp;
    assign retire = valid[head_idx] && resolved[head_idx];

    // Tail is rebuilt from head so the wrap bit stays consistent.
    assign res_offset  = bus.i_res_tag - head_idx;
    assign squash_tail = head + ptr_t'(res_offset) + ptr_t'(1);

    assign redirect_next = (bus.i_res_outcome == TAKEN)
                         ? bus.i_res_target
                         : entries[bus.i_res_tag].pc + ADDR_WIDTH'(FALLTHROUGH_OFFSET);

    always_comb begin
        alloc_mask   = '0;
        resolve_mask = '0;
        retire_mask  = '0;
        squash_mask  = '0;
        if (alloc)
            alloc_mask[tail_idx] = 1'b1;
        if (res_hit)
            resolve_mask[bus.i_res_tag] = 1'b1;
        if (retire)
            retire_mask[head_idx] = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            if (res_misp && (idx_t'(idx_t'(i) - head_idx) > res_offset))
                squash_mask[i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head     <= '0;
            tail     <= '0;
            valid    <= '0;
            resolved <= '0;
        end else begin
            valid    <= (valid & ~squash_mask & ~retire_mask) | alloc_mask;
            resolved <= (resolved | resolve_mask) & ~squash_mask & ~retire_mask & ~alloc_mask;
            if (retire)
                head <= head + ptr_t'(1);
            if (res_misp)
                tail <= squash_tail;
            else if (alloc)
                tail <= tail + ptr_t'(1);
        end
    end

    // Payload needs no reset: valid/resolved gate every read.
    always_ff @(posedge clk) begin
        if (alloc) begin
            entries[tail_idx].pc         <= bus.i_pred_pc;
            entries[tail_idx].target     <= bus.i_pred_target;
            entries[tail_idx].prediction <= bus.i_pred_prediction;
            entries[tail_idx].outcome    <= NOT_TAKEN;
        end
        if (res_hit)
            entries[bus.i_res_tag].outcome <= bus.i_res_outcome;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fb_valid      <= 1'b0;
            fb_pc         <= '0;
            fb_prediction <= NOT_TAKEN;
            fb_outcome    <= NOT_TAKEN;
            mispredict    <= 1'b0;
            redirect_pc   <= '0;
        end else begin
            fb_valid   <= retire;
            mispredict <= res_misp;
            if (retire) begin
                fb_pc         <= entries[head_idx].pc;
                fb_prediction <= entries[head_idx].prediction;
                fb_outcome    <= entries[head_idx].outcome;
            end
            if (res_misp)
                redirect_pc <= redirect_next;
        end
    end

    assign bus.o_fb_valid      = fb_valid;
    assign bus.o_fb_pc         = fb_pc;
    assign bus.o_fb_prediction = fb_prediction;
    assign bus.o_fb_outcome    = fb_outcome;
    assign bus.o_mispredict    = mispredict;
    assign bus.o_redirect_pc   = redirect_pc;

    branch_stats_counter u_stats (
        .clk              (clk),
        .rst_n            (rst_n),
        .inc_branch       (retire),
        .inc_mispredict   (res_misp),
        .branch_count     (bus.o_branch_count),
        .mispredict_count (bus.o_mispredict_count)
    );

endmodule
